// File: rtl/counter_sched.sv
// Round-robin scheduler that lends one shared free-running counter to two
// requesters as an interval timer. All outputs are registered.
// Optional build macro: CNT_SCHED_FIXED_PRIO_EN selects fixed priority
// (requester 0 always wins a tie) instead of round-robin.
module counter_sched #(
    parameter int unsigned BW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_i,
    input  logic [BW-1:0] len0_i,
    input  logic [BW-1:0] len1_i,
    input  logic          abort_i,
    input  logic [BW-1:0] cnt_val_i,
    output logic          cnt_rst_o,
    output logic [1:0]    grant_o,
    output logic [1:0]    done_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] len_q, len_d;
    logic [1:0]    grant_d, done_d;
    logic          busy_d, cnt_rst_d;
    logic          win;  // index of the requester that wins arbitration this cycle

`ifdef CNT_SCHED_FIXED_PRIO_EN
    // Requester 0 has priority whenever it requests.
    always_comb begin
        win = ~req_i[0];
    end
`else
    logic last_q, last_d;

    // A tie goes to the requester that did not win the last tie.
    always_comb begin
        if (req_i == 2'b11) begin
            win = ~last_q;
        end else begin
            win = ~req_i[0];
        end
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        grant_d   = grant_o;
        done_d    = 2'b00;
        busy_d    = busy_o;
        cnt_rst_d = cnt_rst_o;
`ifndef CNT_SCHED_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                grant_d   = 2'b00;
                busy_d    = 1'b0;
                cnt_rst_d = 1'b1;
                if (req_i != 2'b00) begin
                    state_d   = StRun;
                    grant_d   = win ? 2'b10 : 2'b01;
                    len_d     = win ? len1_i : len0_i;
                    busy_d    = 1'b1;
                    cnt_rst_d = 1'b0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
                    if (req_i == 2'b11) begin
                        last_d = win;
                    end
`endif
                end
            end
            StRun: begin
                if (abort_i) begin
                    // Cancelled interval: straight back to idle, no completion pulse.
                    state_d   = StIdle;
                    grant_d   = 2'b00;
                    busy_d    = 1'b0;
                    cnt_rst_d = 1'b1;
                end else if (cnt_val_i == len_q) begin
                    state_d   = StDone;
                    done_d    = grant_o;
                    grant_d   = 2'b00;
                    busy_d    = 1'b1;
                    cnt_rst_d = 1'b1;
                end
            end
            StDone: begin
                state_d   = StIdle;
                grant_d   = 2'b00;
                busy_d    = 1'b0;
                cnt_rst_d = 1'b1;
            end
            default: begin
                state_d   = StIdle;
                grant_d   = 2'b00;
                busy_d    = 1'b0;
                cnt_rst_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            len_q     <= '0;
            grant_o   <= 2'b00;
            done_o    <= 2'b00;
            busy_o    <= 1'b0;
            cnt_rst_o <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            grant_o   <= grant_d;
            done_o    <= done_d;
            busy_o    <= busy_d;
            cnt_rst_o <= cnt_rst_d;
        end
    end

`ifndef CNT_SCHED_FIXED_PRIO_EN
    // Round-robin pointer; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural model of the shared counter.
module tb_counter_sched;

    localparam int unsigned BW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [1:0]    req_i = 2'b00;
    logic [BW-1:0] len0_i = '0;
    logic [BW-1:0] len1_i = '0;
    logic          abort_i = 1'b0;
    logic [BW-1:0] cnt_val_i;
    logic          cnt_rst_o;
    logic [1:0]    grant_o;
    logic [1:0]    done_o;
    logic          busy_o;

    int total = 0;
    int bad = 0;

    counter_sched #(.BW(BW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .len0_i    (len0_i),
        .len1_i    (len1_i),
        .abort_i   (abort_i),
        .cnt_val_i (cnt_val_i),
        .cnt_rst_o (cnt_rst_o),
        .grant_o   (grant_o),
        .done_o    (done_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Shared counter: synchronous reset, +1 per clock, wraps.
    always_ff @(posedge clk_i) begin
        if (cnt_rst_o) cnt_val_i <= '0;
        else           cnt_val_i <= cnt_val_i + 1'b1;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
        total++; if (done_o !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", done_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (cnt_rst_o !== 1'b1) begin bad++; $display("FAIL reset_cnt_rst got=%b exp=1", cnt_rst_o); end
        total++; if (cnt_val_i !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_val_i); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_i = 2'b01; len0_i = 3'd3;
        step();  // grant edge N
        req_i = 2'b00;
        total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", grant_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy_o); end
        total++; if (cnt_rst_o !== 1'b0) begin bad++; $display("FAIL single_cnt_rst got=%b exp=0", cnt_rst_o); end
        total++; if (cnt_val_i !== 3'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", cnt_val_i); end
        for (int k = 1; k <= 3; k++) begin
            step();
            total++; if (cnt_val_i !== 3'(k)) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", cnt_val_i, k); end
            total++; if (grant_o !== 2'b01 || done_o !== 2'b00) begin bad++; $display("FAIL single_run got=g%b/d%b exp=g01/d00", grant_o, done_o); end
        end
        step();
        total++; if (done_o !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", done_o); end
        total++; if (grant_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL single_done_state got=g%b/b%b exp=g00/b1", grant_o, busy_o); end
        step();
        total++; if (done_o !== 2'b00) begin bad++; $display("FAIL single_pulse_len got=%b exp=00", done_o); end
        total++; if (busy_o !== 1'b0 || cnt_rst_o !== 1'b1) begin bad++; $display("FAIL single_idle got=b%b/r%b exp=b0/r1", busy_o, cnt_rst_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        int len;
        req_i = 2'b11; len0_i = 3'd2; len1_i = 3'd1;
        for (int i = 0; i < 3; i++) begin
`ifdef CNT_SCHED_FIXED_PRIO_EN
            g = 2'b01;
`else
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            len = (g == 2'b01) ? 2 : 1;
            step();
            total++; if (grant_o !== g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant_o, g); end
            repeat (len) step();
            total++; if (grant_o !== g || done_o !== 2'b00) begin bad++; $display("FAIL rr_run%0d got=g%b/d%b exp=g%b/d00", i, grant_o, done_o, g); end
            step();
            total++; if (done_o !== g) begin bad++; $display("FAIL rr_done%0d got=%b exp=%b", i, done_o, g); end
            step();  // DONE -> IDLE even with req held
            total++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=g%b/b%b exp=g00/b0", i, grant_o, busy_o); end
        end
        req_i = 2'b00;
        step();
    endtask

    task automatic test_zero_len();
        req_i = 2'b10; len1_i = 3'd0;
        step();
        req_i = 2'b00;
        total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL zero_grant got=%b exp=10", grant_o); end
        step();
        total++; if (done_o !== 2'b10) begin bad++; $display("FAIL zero_done got=%b exp=10", done_o); end
        step();
        total++; if (busy_o !== 1'b0 || done_o !== 2'b00) begin bad++; $display("FAIL zero_idle got=b%b/d%b exp=b0/d00", busy_o, done_o); end
    endtask

    task automatic test_abort();
        req_i = 2'b01; len0_i = 3'd7;
        step();  // RUN cycle 1
        req_i = 2'b00;
        step();  // RUN cycle 2
        step();  // RUN cycle 3
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        total++; if (grant_o !== 2'b00 || done_o !== 2'b00) begin bad++; $display("FAIL abort_out got=g%b/d%b exp=g00/d00", grant_o, done_o); end
        total++; if (cnt_rst_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle got=r%b/b%b exp=r1/b0", cnt_rst_o, busy_o); end
        for (int k = 0; k < 8; k++) begin
            step();
            total++; if (done_o !== 2'b00) begin bad++; $display("FAIL abort_nopulse got=%b exp=00", done_o); end
        end
    endtask

    task automatic test_mid_run();
        req_i = 2'b01; len0_i = 3'd5;
        step();
        req_i = 2'b00; len0_i = 3'd1;
        repeat (5) step();
        total++; if (cnt_val_i !== 3'd5 || done_o !== 2'b00) begin bad++; $display("FAIL mid_cnt got=c%0d/d%b exp=c5/d00", cnt_val_i, done_o); end
        step();
        total++; if (done_o !== 2'b01) begin bad++; $display("FAIL mid_done got=%b exp=01", done_o); end
        step();
        // Reset in the middle of a fresh interval.
        req_i = 2'b01; len0_i = 3'd5;
        step();
        req_i = 2'b00;
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if (grant_o !== 2'b00 || busy_o !== 1'b0 || cnt_rst_o !== 1'b1) begin bad++; $display("FAIL midrst_vals got=g%b/b%b/r%b exp=g00/b0/r1", grant_o, busy_o, cnt_rst_o); end
        for (int k = 0; k < 8; k++) begin
            total++; if (done_o !== 2'b00) begin bad++; $display("FAIL midrst_nopulse got=%b exp=00", done_o); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one `counter` instance (BW-bit, synchronous reset to 0, +1 per clk, wraps mod 2^BW) between two requesters as an interval timer.
- Drives the counter's reset input and watches its count value.
- Grants the counter to one requester at a time, times an interval of programmable length, and returns a one-cycle done pulse to the owner.
- Sits between the top-level `tt_um_counter` glue and the shared counter.

Parameters:
- BW, 3, width of counter value and interval length fields

Ports:
- clk_i  in  1  clock, same clock as the shared counter
- rst_i  in  1  reset, synchronous active-high
- req_i  in  2  request, bit k from requester k; level-sensitive
- len0_i  in  BW  interval length for requester 0, sampled at grant
- len1_i  in  BW  interval length for requester 1, sampled at grant
- abort_i  in  1  cancel the current interval
- cnt_val_i  in  BW  counter_val_o of the shared counter
- cnt_rst_o  out  1  drives rst_i of the shared counter
- grant_o  out  2  one-hot owner of the counter, all-zero when idle
- done_o  out  2  one-cycle completion pulse, bit k to requester k
- busy_o  out  1  high while not IDLE

Behaviour:
- One clock, clk_i. Reset is synchronous, active-high on rst_i.
- Reset values, in effect on the edge after rst_i is sampled high:
  - state=IDLE, grant_o=0, done_o=0, busy_o=0, cnt_rst_o=1.
  - Round-robin pointer last_q=1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - cnt_rst_o=1, holding the counter at 0.
  - If req_i!=0: pick the winner, latch len_q from the winner's len input, set grant_o one-hot, go to RUN.
  - Arbitration:
    - Single requester wins.
    - Both requesting: winner = ~last_q; last_q updated to the winner.
- RUN:
  - cnt_rst_o=0, so the counter counts 0,1,2,...
  - grant_o and busy_o held; req_i and len inputs ignored.
  - When cnt_val_i==len_q: go to DONE, with done_o[owner]=1 in the DONE cycle.
  - RUN therefore lasts len_q+1 cycles.
  - len_q=0 is legal: one RUN cycle.
- DONE:
  - done_o pulse for exactly one cycle.
  - grant_o=0, cnt_rst_o=1, busy_o=1.
  - Next state IDLE unconditionally. No back-to-back grant; minimum 1 IDLE cycle between intervals.
- Latency, req_i first sampled high at edge N in IDLE:
  - grant_o high from N+1.
  - done_o high in cycle N+len+2.
  - busy_o low from N+len+3.
- abort_i:
  - Sampled high in RUN: go to IDLE directly, no done_o pulse, grant_o=0, cnt_rst_o=1.
  - Ignored in IDLE and DONE.
- Requester dropping req_i during RUN: interval still completes and done_o still pulses.
- rst_i mid-interval: returns to the reset values next edge, no done_o pulse.
- Requester bits never both set in grant_o or done_o.

Optional Feature:
- Macro CNT_SCHED_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, requester 0 always wins when both request.
  - last_q removed.
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst_i=1 for 3 cycles -> grant_o=00, done_o=00, busy_o=0, cnt_rst_o=1, cnt_val_i=0.
- Single request: req_i=01, len0_i=3 at edge N -> grant_o=01 from N+1, cnt_val_i 0..3 during RUN, done_o=01 only in cycle N+5, busy_o=0 at N+6.
- Round-robin: req_i=11 held, len0_i=2, len1_i=1:
  - Grants alternate 01,10,01 with done_o pulses matching.
  - With CNT_SCHED_FIXED_PRIO_EN, grant_o=01 every interval.
- Zero length: req_i=10, len1_i=0 -> one RUN cycle, done_o=10 two cycles after the grant edge.
- Abort: req_i=01, len0_i=7; abort_i=1 at 3rd RUN cycle -> next cycle IDLE, grant_o=00, no done_o pulse, cnt_rst_o=1.
- Mid-run changes: req_i dropped and len0_i changed to 1 during RUN with len_q=5 -> interval still ends at cnt_val_i=5 with done_o=01. A later rst_i=1 mid-RUN -> reset values, no pulse.
